// File: rtl/uart_pkg.sv
// Shared UART definitions: the transmitter state encoding and the
// bit-period calculation used by the transmitter and a future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } UART_TX_STATE;

  // Clock cycles per serial bit, truncated toward zero.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// count of each period. clear holds it at zero so that a new period always
// begins from a known phase.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Free-running modulo counter, restarted by reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/uart_tx_port.sv
// 8N1 UART transmitter. A single-cycle trigger in IDLE latches a byte and
// sends start bit, 8 data bits LSB first and one stop bit, then pulses
// io_output_ready_trigger for one cycle. Triggers outside IDLE are dropped.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_output_trigger,
  input  logic [7:0] io_output_value,
  output logic       io_output_ready_trigger,
  output logic       tx,
  output logic       busy
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_port: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  UART_TX_STATE state_q, state_d;
  logic [7:0]   shift_q, shift_d;
  logic [2:0]   bit_q, bit_d;
  logic         tx_q, tx_d;
  logic         baud_clear;
  logic         baud_tick;

  // The timer only runs while a bit is on the line, so the start bit
  // always begins a fresh period.
  assign baud_clear = (state_q == IDLE) || (state_q == DONE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  // State, shift register, bit index and the registered line driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; tx_d is the line level for the coming cycle so the
  // pin comes straight off a flop.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (io_output_trigger) begin
          state_d = START;
          shift_d = io_output_value;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = DONE;
          tx_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx                      = tx_q;
  assign busy                    = (state_q != IDLE);
  assign io_output_ready_trigger = (state_q == DONE);

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: a fast instance (CLKS_PER_BIT=4) for the
// functional scenarios and a default-parameter instance for bit timing.
module tb_uart_tx_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic [7:0] val;
  logic       rdy, tx, busy;

  logic       dd_trig;
  logic [7:0] dd_val;
  logic       dd_rdy, dd_tx, dd_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic tx_log   [0:127];
  logic rdy_log  [0:127];
  logic busy_log [0:127];

  always #5 clk = ~clk;

  uart_tx_port #(.CLKS_PER_BIT(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .io_output_trigger      (trig),
    .io_output_value        (val),
    .io_output_ready_trigger(rdy),
    .tx                     (tx),
    .busy                   (busy)
  );

  uart_tx_port dut_def (
    .clk                    (clk),
    .rst                    (rst),
    .io_output_trigger      (dd_trig),
    .io_output_value        (dd_val),
    .io_output_ready_trigger(dd_rdy),
    .tx                     (dd_tx),
    .busy                   (dd_busy)
  );

  // Expected line level i cycles after the acceptance edge (CLKS_PER_BIT=4).
  function automatic logic exp_tx(input logic [7:0] v, input int i);
    if (i >= 0 && i < 4) return 1'b0;
    if (i >= 4 && i < 36) return v[(i - 4) / 4];
    return 1'b1;
  endfunction

  // Triggers v, then records n samples taken 1 time unit after each edge.
  // Sample 0 is the cycle right after the acceptance edge. Optionally pulses
  // trigger (with inj_v) or rst during the cycle of a given sample index.
  task automatic capture(input logic [7:0] v, input int n, input int inj_idx,
                         input logic [7:0] inj_v, input int rst_idx);
    trig = 1'b1;
    val  = v;
    @(posedge clk); #1;
    trig = 1'b0;
    for (int i = 0; i < n; i++) begin
      tx_log[i]   = tx;
      rdy_log[i]  = rdy;
      busy_log[i] = busy;
      trig = (i == inj_idx);
      val  = (i == inj_idx) ? inj_v : 8'h00;
      rst  = (i == rst_idx);
      @(posedge clk); #1;
    end
    trig = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({tx, busy, rdy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_state got tx,busy,rdy=%b expected 100", {tx, busy, rdy});
    end
    n_cmp++;
    if ({dd_tx, dd_busy, dd_rdy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_state_default got tx,busy,rdy=%b expected 100", {dd_tx, dd_busy, dd_rdy});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({tx, busy, rdy} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_after_reset got tx,busy,rdy=%b expected 100", {tx, busy, rdy});
    end
  endtask

  task automatic test_frame_a5();
    logic [2:0] e;
    capture(8'hA5, 42, -1, 8'h00, -1);
    for (int i = 0; i < 42; i++) begin
      e = {exp_tx(8'hA5, i), (i <= 40), (i == 40)};
      n_cmp++;
      if ({tx_log[i], busy_log[i], rdy_log[i]} !== e) begin
        n_fail++;
        $display("FAIL frame_a5[%0d] got tx,busy,rdy=%b expected %b", i,
                 {tx_log[i], busy_log[i], rdy_log[i]}, e);
      end
    end
  endtask

  task automatic test_ignore_trigger();
    logic [2:0] e;
    int pulses;
    pulses = 0;
    capture(8'h3C, 50, 10, 8'hFF, -1);
    for (int i = 0; i < 50; i++) begin
      e = {exp_tx(8'h3C, i), (i <= 40), (i == 40)};
      if (rdy_log[i] === 1'b1) pulses++;
      n_cmp++;
      if ({tx_log[i], busy_log[i], rdy_log[i]} !== e) begin
        n_fail++;
        $display("FAIL ignore_trig[%0d] got tx,busy,rdy=%b expected %b", i,
                 {tx_log[i], busy_log[i], rdy_log[i]}, e);
      end
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL ignore_trig_pulses got %0d expected 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    capture(8'h01, 84, 41, 8'h80, -1);
    for (int i = 0; i < 84; i++) begin
      if (i <= 41) e = {exp_tx(8'h01, i), (i <= 40), (i == 40)};
      else         e = {exp_tx(8'h80, i - 42), (i <= 82), (i == 82)};
      n_cmp++;
      if ({tx_log[i], busy_log[i], rdy_log[i]} !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] got tx,busy,rdy=%b expected %b", i,
                 {tx_log[i], busy_log[i], rdy_log[i]}, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [2:0] e;
    // Samples 16..19 carry data bit 3; reset is held during sample 17.
    capture(8'hA5, 40, -1, 8'h00, 17);
    for (int i = 0; i < 40; i++) begin
      if (i <= 17) e = {exp_tx(8'hA5, i), 1'b1, 1'b0};
      else         e = 3'b100;
      n_cmp++;
      if ({tx_log[i], busy_log[i], rdy_log[i]} !== e) begin
        n_fail++;
        $display("FAIL rst_mid_frame[%0d] got tx,busy,rdy=%b expected %b", i,
                 {tx_log[i], busy_log[i], rdy_log[i]}, e);
      end
    end
    capture(8'h55, 42, -1, 8'h00, -1);
    for (int i = 0; i < 42; i++) begin
      e = {exp_tx(8'h55, i), (i <= 40), (i == 40)};
      n_cmp++;
      if ({tx_log[i], busy_log[i], rdy_log[i]} !== e) begin
        n_fail++;
        $display("FAIL frame_55[%0d] got tx,busy,rdy=%b expected %b", i,
                 {tx_log[i], busy_log[i], rdy_log[i]}, e);
      end
    end
  endtask

  task automatic test_rst_with_trigger();
    rst  = 1'b1;
    trig = 1'b1;
    val  = 8'h00;
    @(posedge clk); #1;
    rst  = 1'b0;
    trig = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({tx, busy, rdy} !== 3'b100) begin
        n_fail++;
        $display("FAIL rst_and_trig[%0d] got tx,busy,rdy=%b expected 100", i, {tx, busy, rdy});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_default_baud();
    int low_cnt;
    int rdy_idx;
    low_cnt = 0;
    rdy_idx = -1;
    dd_trig = 1'b1;
    dd_val  = 8'h00;
    @(posedge clk); #1;
    dd_trig = 1'b0;
    // Start bit plus eight zero bits: 9 bit periods of 434 cycles each.
    for (int i = 0; i < 4400; i++) begin
      if (dd_tx === 1'b0) low_cnt++;
      if (dd_rdy === 1'b1 && rdy_idx < 0) rdy_idx = i;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (low_cnt !== 9 * 434) begin
      n_fail++;
      $display("FAIL default_low_cycles got %0d expected %0d", low_cnt, 9 * 434);
    end
    n_cmp++;
    if (rdy_idx !== 10 * 434) begin
      n_fail++;
      $display("FAIL default_ready_idx got %0d expected %0d", rdy_idx, 10 * 434);
    end
  endtask

  initial begin
    rst     = 1'b1;
    trig    = 1'b0;
    val     = 8'h00;
    dd_trig = 1'b0;
    dd_val  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_frame_a5();
    test_ignore_trigger();
    test_back_to_back();
    test_reset_mid_frame();
    test_rst_with_trigger();
    test_default_baud();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
